// File: rtl/raw_pixel_capture.sv
// raw_pixel_capture
//   Samples raw Bayer pixels from the D5M sensor interface and turns them into
//   the coordinate-tagged pixel stream consumed by the image-processing stage.
//   Capture is armed by iSTART and disarmed by iEND. A frame is captured only
//   if capture is armed when its FVAL rising edge is seen; once started, a
//   frame always runs to its FVAL falling edge.
//
// Ports
//   iCLK        pixel clock, all logic on the rising edge
//   iRST        synchronous active-high reset
//   iDATA       raw sensor pixel
//   iFVAL       sensor frame valid
//   iLVAL       sensor line valid
//   iSTART      arms capture (pulse or level)
//   iEND        disarms capture (pulse or level), wins over iSTART
//   oDATA       captured pixel, two cycles after it was on iDATA
//   oX_Cont     column of the pixel on oDATA
//   oY_Cont     row of the pixel on oDATA (saturates at all-ones)
//   oDVAL       oDATA/oX_Cont/oY_Cont valid this cycle (registered)
//   oFrame_Cont number of frames captured since reset
module raw_pixel_capture #(
    parameter int DATA_W       = 12,
    parameter int XY_W         = 11,
    parameter int COLUMN_WIDTH = 1280,
    parameter int FRAME_W      = 32
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [DATA_W-1:0]  iDATA,
    input  logic               iFVAL,
    input  logic               iLVAL,
    input  logic               iSTART,
    input  logic               iEND,
    output logic [DATA_W-1:0]  oDATA,
    output logic [XY_W-1:0]    oX_Cont,
    output logic [XY_W-1:0]    oY_Cont,
    output logic               oDVAL,
    output logic [FRAME_W-1:0] oFrame_Cont
);

    typedef enum logic {IDLE, FRAME} state_t;

    localparam logic [XY_W-1:0] X_LAST = XY_W'(COLUMN_WIDTH - 1);
    localparam logic [XY_W-1:0] Y_MAX  = '1;

    logic [DATA_W-1:0] data_p1;
    logic              fval_p1;
    logic              lval_p1;
    logic              prev_fval;
    logic              armed;
    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              frame_start;
    logic [XY_W-1:0]   x_cnt;
    logic [XY_W-1:0]   y_cnt;

    // Stage 1: input registers and FVAL edge history
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            data_p1   <= '0;
            fval_p1   <= 1'b0;
            lval_p1   <= 1'b0;
            prev_fval <= 1'b0;
        end else begin
            data_p1   <= iDATA;
            fval_p1   <= iFVAL;
            lval_p1   <= iLVAL;
            prev_fval <= fval_p1;
        end
    end

    // Arm flag follows the raw controls; a simultaneous stop beats start.
    always_ff @(posedge iCLK) begin
        if (iRST)        armed <= 1'b0;
        else if (iEND)   armed <= 1'b0;
        else if (iSTART) armed <= 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else      state <= state_next;
    end

    // The pixel coincident with the FVAL rising edge belongs to the new frame,
    // so acceptance is already granted on the IDLE->FRAME transition.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (fval_p1 && !prev_fval && armed) begin
                    state_next  = FRAME;
                    frame_start = 1'b1;
                    accept      = lval_p1;
                end
            end
            FRAME: begin
                if (!fval_p1 && prev_fval) state_next = IDLE;
                else                       accept     = fval_p1 && lval_p1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Coordinate counters: LVAL falling is deliberately ignored, so short
    // lines carry X over into the next line. Counters sit at 0 outside frames.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                if (y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end else if (state_next == IDLE) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end
    end

    // Stage 2: output registers; data and coordinates hold when not accepted
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDATA       <= '0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oDVAL       <= 1'b0;
            oFrame_Cont <= '0;
        end else begin
            oDVAL <= accept;
            if (accept) begin
                oDATA   <= data_p1;
                oX_Cont <= x_cnt;
                oY_Cont <= y_cnt;
            end
            if (frame_start) oFrame_Cont <= oFrame_Cont + FRAME_W'(1);
        end
    end

endmodule

// File: doc/raw_pixel_capture.md
Name: raw_pixel_capture

Overview:
- Upstream neighbour of the image-processing stage.
- Samples raw 12-bit Bayer data from the D5M sensor interface (FVAL/LVAL framing) and gates capture with start/stop controls.
- Produces the pixel stream the image-processing stage consumes: oDATA, oX_Cont, oY_Cont and oDVAL, plus a frame counter for the display.

Parameters:
- DATA_W, 12, raw pixel width.
- XY_W, 11, width of the column and row counters.
- COLUMN_WIDTH, 1280, pixels per line; the X counter wraps at COLUMN_WIDTH-1.
- FRAME_W, 32, frame counter width.

Ports:
- iCLK  in  1  pixel clock. Single clock domain; all logic on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iDATA  in  DATA_W  raw sensor pixel.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid.
- iSTART  in  1  pulse or level; arms capture.
- iEND  in  1  pulse or level; disarms capture.
- oDATA  out  DATA_W  captured pixel.
- oX_Cont  out  XY_W  column of the pixel on oDATA.
- oY_Cont  out  XY_W  row of the pixel on oDATA.
- oDVAL  out  1  oDATA/oX_Cont/oY_Cont valid this cycle.
- oFrame_Cont  out  FRAME_W  number of frames captured since reset.

Behaviour:
- Reset (iRST=1 at a clock edge): all registers and outputs are 0, including oDATA, oX_Cont, oY_Cont, oDVAL, oFrame_Cont, the arm flag, the frame-active flag, the input registers and the counters. Reset asserted mid-frame aborts the frame. After reset release, capture waits for iSTART and then the next FVAL rising edge.
- Input stage: iDATA, iFVAL and iLVAL are registered once (stage 1). prev_FVAL holds the stage-1 FVAL from the previous cycle, for edge detection.
- Arm flag:
  - Set by iSTART.
  - Cleared by iEND.
  - If iSTART and iEND are both high, iEND wins.
  - Updated from the raw inputs each cycle.
- Frame-active state machine, two states: IDLE and FRAME.
  - IDLE -> FRAME when stage-1 FVAL=1, prev_FVAL=0 and the arm flag is 1. oFrame_Cont increments by 1 on this transition, wrapping modulo 2^FRAME_W.
  - FRAME -> IDLE when stage-1 FVAL=0 and prev_FVAL=1.
  - iEND during FRAME does not truncate the current frame; no new frame starts afterwards.
  - An FVAL rising edge while disarmed is ignored for the whole frame, even if iSTART arrives mid-frame.
- Pixel acceptance: a pixel is accepted iff it is sampled with stage-1 LVAL=1 and FVAL=1, and it belongs to a frame that entered FRAME. This includes the pixel coincident with the FVAL rising edge.
- Latency: an accepted pixel appears on oDATA with oDVAL=1 exactly 2 cycles after it was present on iDATA.
- Coordinates:
  - Internal X and Y counters are 0 in IDLE.
  - On each accepted pixel, oX_Cont and oY_Cont receive the current X and Y.
  - X then increments. At X=COLUMN_WIDTH-1, X wraps to 0 and Y increments.
  - Y saturates at 2^XY_W-1.
  - LVAL falling does not affect the counters. Lines shorter than COLUMN_WIDTH therefore continue X on the next line (documented behaviour, not an error).
- Non-accepted cycles: oDVAL=0, and oDATA, oX_Cont and oY_Cont hold their previous values.
- oDVAL is fully registered, with no combinational path from any input.

Test Plan:
1. Reset behaviour: hold iRST=1 for 5 cycles with random iDATA and FVAL/LVAL toggling -> all outputs 0 throughout; oFrame_Cont stays 0.
2. Armed frame: COLUMN_WIDTH=8; pulse iSTART; drive FVAL high for 3 lines of 8 pixels each (LVAL high 8 cycles, low 4), with iDATA = incrementing values 0..23 -> 24 oDVAL pulses. Each oDATA equals its input value, 2 cycles later. (X,Y) runs (0,0)..(7,0),(0,1)..(7,2). oFrame_Cont=1.
3. Disarmed / stop gating:
   - Frame sent without iSTART -> no oDVAL, oFrame_Cont=0.
   - iEND asserted mid-frame while armed -> that frame completes all 24 pixels; next frame produces no oDVAL; oFrame_Cont unchanged.
4. Simultaneous start/end: iSTART=iEND=1 in the same cycle, then a frame -> no capture.
   - iSTART asserted mid-frame -> that frame is ignored; the following frame is captured with coordinates starting at (0,0).
5. Reset mid-frame: assert iRST after pixel (3,1) -> outputs 0 the next cycle. Remaining pixels of that frame are ignored. After iSTART, the next frame restarts at (0,0) with oFrame_Cont=1.
6. Saturation and short lines:
   - XY_W=3, COLUMN_WIDTH=2, frame of 10 lines -> oY_Cont saturates at 7.
   - Line of 5 pixels with COLUMN_WIDTH=8 -> next line begins at X=5.
